launch_queue: RTL and testbench
===============================

LAUNCH_QUEUE -- requirements
Module: launch_queue

Interface
REQ-001 Parameter: QUEUE_DEPTH, default 4, number of buffered kernel-launch commands; power of two, minimum 2.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  host offers a launch command.
REQ-005 cmd_thread_count  input  8  thread count of the offered command.
REQ-006 cmd_ready  output  1  queue accepts the command this cycle.
REQ-007 disp_start  output  1  start request to the block dispatcher; registered.
REQ-008 disp_thread_count  output  8  thread count presented to the dispatcher; registered.
REQ-009 disp_done  input  1  dispatcher completion flag.
REQ-010 launch_done  output  1  one-cycle pulse per retired command.
REQ-011 busy  output  1  a command is queued or in flight.
REQ-012 queue_count  output  $clog2(QUEUE_DEPTH)+1  number of commands held in the queue.
REQ-013 launches_completed  output  8  retired-command counter.
REQ-014 last_cycles  output  16  cycle duration of the most recently retired command.

Function
REQ-015 Queue: FIFO of QUEUE_DEPTH 8-bit entries; push when cmd_valid && cmd_ready; cmd_ready = (queue_count != QUEUE_DEPTH).
REQ-016 A push while full is blocked, even if a pop occurs in the same cycle; a simultaneous push and pop when not full leaves queue_count unchanged.
REQ-017 No bypass: a pushed entry becomes poppable in the cycle after the push at the earliest.
REQ-018 FSM states: IDLE, LAUNCH, DRAIN.
REQ-019 In IDLE with the queue non-empty and head != 0, the block pops the head, loads disp_thread_count with the head, sets disp_start=1, clears the cycle counter to 0, and goes to LAUNCH.
REQ-020 In IDLE with head == 0, the block pops the head, pulses launch_done, increments launches_completed, sets last_cycles=0, stays in IDLE, and leaves disp_start at 0.
REQ-021 In LAUNCH, disp_start stays at 1, disp_thread_count stays stable, and the cycle counter increments each cycle, saturating at 16'hFFFF.
REQ-022 In LAUNCH with disp_done=1, the block sets disp_start=0, pulses launch_done, increments launches_completed (wraps mod 256), loads last_cycles with the cycle counter, and goes to DRAIN.
REQ-023 In DRAIN, disp_start=0 and disp_thread_count is held; when disp_done=0 the block goes to IDLE; no pop occurs while in DRAIN.
REQ-024 Back-to-back launches: disp_start is low for at least one cycle between commands, and the next launch begins only from IDLE.
REQ-025 busy = (state != IDLE) || (queue_count != 0).
REQ-026 disp_done is ignored in IDLE.
REQ-027 Pushes are accepted in all states subject to cmd_ready.

Reset
REQ-028 On reset: state=IDLE; queue emptied (queue_count=0); cmd_ready=1; disp_start=0; disp_thread_count=0; launch_done=0; busy=0; launches_completed=0; last_cycles=0; cycle counter=0.
REQ-029 Reset mid-LAUNCH or mid-DRAIN discards the in-flight command and all queued commands without a launch_done pulse; disp_start is 0 in the first cycle after reset.

Verification
REQ-030 Single launch: push 10 while idle; disp_done rises 7 cycles after disp_start -> disp_thread_count=10 while disp_start=1, one launch_done pulse, last_cycles=7, launches_completed=1, busy=0 after disp_done falls.
REQ-031 Full queue: QUEUE_DEPTH=4; push 5 commands while the dispatcher is held busy -> 4 commands accepted (queue_count=4); cmd_ready=0 during the fifth attempt; 5th accepted only after the first pop.
REQ-032 Ordering: push 3, 8, 1 -> dispatcher sees 3, 8, 1 in order; disp_start low at least one cycle between commands; launches_completed=3.
REQ-033 Zero-thread command: push 0 then 4 -> launch_done pulse with no disp_start for the first, last_cycles=0; second launches normally.
REQ-034 Held done: disp_done stays 1 for 5 cycles after disp_start falls -> FSM holds in DRAIN, no second pop, next launch 1 cycle after disp_done=0.
REQ-035 Reset mid-LAUNCH: two commands queued, reset asserted -> next cycle disp_start=0, queue_count=0, launches_completed=0, no launch_done pulse.

Source files
------------

// File: rtl/launch_queue.sv
// ---------------------------------------------------------------------------
// launch_queue
//
// Buffers kernel-launch commands from a host and hands them to a block
// dispatcher one at a time. Each command is only a thread count. A command
// with a thread count of zero is retired on the spot without involving the
// dispatcher. Every other command goes through a start/done handshake with
// the dispatcher. The block also counts retired commands and records how
// many cycles the last one took.
//
// Parameters
//   QUEUE_DEPTH        number of buffered commands (power of two, >= 2)
//
// Ports
//   clk                clock, rising edge
//   reset              synchronous, active-high reset
//   cmd_valid          host offers a command this cycle
//   cmd_thread_count   thread count of the offered command
//   cmd_ready          queue can accept a command this cycle
//   disp_start         start request to the dispatcher (registered)
//   disp_thread_count  thread count presented to the dispatcher (registered)
//   disp_done          dispatcher completion flag
//   launch_done        one-cycle pulse per retired command (registered)
//   busy               a command is queued or in flight
//   queue_count        number of commands held in the queue
//   launches_completed retired-command counter, wraps mod 256
//   last_cycles        cycle duration of the most recently retired command
// ---------------------------------------------------------------------------
module launch_queue #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic [7:0]                   cmd_thread_count,
  output logic                         cmd_ready,
  output logic                         disp_start,
  output logic [7:0]                   disp_thread_count,
  input  logic                         disp_done,
  output logic                         launch_done,
  output logic                         busy,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic [7:0]                   launches_completed,
  output logic [15:0]                  last_cycles
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    DRAIN
  } state_t;

  state_t state;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    mem [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // cmd_ready depends only on the registered count. A pop in the same cycle
  // therefore never frees a slot for a push into a full queue.
  assign cmd_ready = (count != COUNT_MAX);
  assign push      = cmd_valid && cmd_ready;

  // Pops come only from IDLE, using the registered count. An entry pushed
  // this cycle is first visible at the head on the following cycle.
  assign pop  = (state == IDLE) && (count != '0);
  assign head = mem[rd_ptr];

  always_comb begin
    // NOTE: always_comb gets a default for every output first, so an
    // uncovered case branch cannot infer a latch.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  // NOTE: the storage array has no reset. After a reset the pointers and the
  // count alone say that the queue is empty, so the stale data is never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_thread_count;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // The depth is a power of two, so the pointers wrap on their own.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  assign queue_count = count;

  // -------------------------------------------------------------------------
  // Launch FSM with registered outputs
  // -------------------------------------------------------------------------
  logic [15:0] cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      disp_start         <= 1'b0;
      disp_thread_count  <= 8'd0;
      launch_done        <= 1'b0;
      launches_completed <= 8'd0;
      last_cycles        <= 16'd0;
      cycle_count        <= 16'd0;
    end else begin
      launch_done <= 1'b0;
      case (state)
        IDLE: begin
          // disp_done is not looked at here. A stale done from the
          // dispatcher cannot retire a command that was never started.
          if (pop) begin
            if (head == 8'd0) begin
              // A command with no threads retires at once and leaves the
              // dispatcher untouched.
              launch_done        <= 1'b1;
              launches_completed <= launches_completed + 8'd1;
              last_cycles        <= 16'd0;
            end else begin
              disp_start        <= 1'b1;
              disp_thread_count <= head;
              cycle_count       <= 16'd0;
              state             <= LAUNCH;
            end
          end
        end

        LAUNCH: begin
          if (disp_done) begin
            disp_start         <= 1'b0;
            launch_done        <= 1'b1;
            launches_completed <= launches_completed + 8'd1;
            last_cycles        <= cycle_count;
            state              <= DRAIN;
          end else if (cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
          end
        end

        DRAIN: begin
          // Wait for the dispatcher to drop done before the next launch is
          // allowed. This also keeps disp_start low for at least one cycle
          // between commands.
          if (!disp_done) begin
            state <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          disp_start <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_launch_queue.sv
// ---------------------------------------------------------------------------
// tb_launch_queue
//
// Self-checking bench for launch_queue with QUEUE_DEPTH = 4. It runs in three
// parts:
//   - a per-cycle vector table for a single launch and a zero-thread command
//   - hand-written sequences for a full queue, ordering, a held done and a
//     reset during a launch
//   - random traffic compared against a command-level reference model
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at that same point, which is well away from the active edge.
// ---------------------------------------------------------------------------
module tb_launch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [7:0]    cmd_thread_count;
  logic          cmd_ready;
  logic          disp_start;
  logic [7:0]    disp_thread_count;
  logic          disp_done;
  logic          launch_done;
  logic          busy;
  logic [CW-1:0] queue_count;
  logic [7:0]    launches_completed;
  logic [15:0]   last_cycles;

  launch_queue #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_thread_count   (cmd_thread_count),
    .cmd_ready          (cmd_ready),
    .disp_start         (disp_start),
    .disp_thread_count  (disp_thread_count),
    .disp_done          (disp_done),
    .launch_done        (launch_done),
    .busy               (busy),
    .queue_count        (queue_count),
    .launches_completed (launches_completed),
    .last_cycles        (last_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] tc, input logic d);
    reset            = r;
    cmd_valid        = v;
    cmd_thread_count = tc;
    disp_done        = d;
  endtask

  // Waits until disp_start is high, stepping at most max_cycles cycles.
  // Running out of cycles counts as a failed comparison.
  task automatic wait_start(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!disp_start && n < max_cycles) begin
      step();
      n++;
    end
    check({name, " start seen"}, disp_start, 1'b1);
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic          rst;
    logic          v;
    logic [7:0]    tc;
    logic          d;
    logic          e_ready;
    logic          e_start;
    logic [7:0]    e_dtc;
    logic          e_ld;
    logic          e_busy;
    logic [CW-1:0] e_cnt;
    logic [7:0]    e_comp;
    logic [15:0]   e_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] tc, input logic d,
                              input logic rdy, input logic st, input logic [7:0] dtc,
                              input logic ld, input logic bsy, input logic [CW-1:0] cnt,
                              input logic [7:0] comp, input logic [15:0] last);
    vec_t x;
    x.rst = rst; x.v = v; x.tc = tc; x.d = d;
    x.e_ready = rdy; x.e_start = st; x.e_dtc = dtc; x.e_ld = ld;
    x.e_busy = bsy; x.e_cnt = cnt; x.e_comp = comp; x.e_last = last;
    return x;
  endfunction

  // -------------------------------------------------------------------------
  // Reference model at the command level: a queue of thread counts plus the
  // command currently held by the dispatcher. The model gives the state
  // just after the next rising edge.
  // -------------------------------------------------------------------------
  logic [7:0]  m_q[$];
  int          m_phase;      // 0 waiting for work, 1 dispatcher running, 2 waiting for done low
  logic        m_start;
  logic [7:0]  m_dtc;
  logic        m_ld;
  int          m_comp;
  int          m_last;
  int          m_elapsed;

  task automatic model_step(input logic r, input logic v, input logic [7:0] tc, input logic d);
    bit can_push;
    logic [7:0] h;
    if (r) begin
      m_q.delete();
      m_phase = 0; m_start = 0; m_dtc = 0; m_ld = 0;
      m_comp = 0; m_last = 0; m_elapsed = 0;
      return;
    end
    can_push = (m_q.size() != DEPTH);
    m_ld = 0;
    if (m_phase == 0) begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        if (h == 0) begin
          m_ld = 1; m_comp = (m_comp + 1) % 256; m_last = 0;
        end else begin
          m_start = 1; m_dtc = h; m_elapsed = 0; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (d) begin
        m_start = 0; m_ld = 1; m_comp = (m_comp + 1) % 256;
        m_last = m_elapsed; m_phase = 2;
      end else if (m_elapsed < 65535) begin
        m_elapsed++;
      end
    end else begin
      if (!d) m_phase = 0;
    end
    if (v && can_push) m_q.push_back(tc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b0, 8'd0, 1'b0);

    // ---------------- vector table ----------------
    //                 rst v  tc    d   rdy st dtc    ld bsy cnt  comp  last
    vecs.push_back(mk(1, 0, 8'd0,  0,  1, 0, 8'd0,  0, 0, 3'd0, 8'd0, 16'd0));
    vecs.push_back(mk(0, 1, 8'd10, 0,  1, 0, 8'd0,  0, 1, 3'd1, 8'd0, 16'd0));
    vecs.push_back(mk(0, 0, 8'd0,  0,  1, 1, 8'd10, 0, 1, 3'd0, 8'd0, 16'd0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, 0, 8'd0, 0, 1, 1, 8'd10, 0, 1, 3'd0, 8'd0, 16'd0));
    vecs.push_back(mk(0, 0, 8'd0,  1,  1, 0, 8'd10, 1, 1, 3'd0, 8'd1, 16'd7));
    vecs.push_back(mk(0, 0, 8'd0,  0,  1, 0, 8'd10, 0, 0, 3'd0, 8'd1, 16'd7));
    vecs.push_back(mk(0, 0, 8'd0,  1,  1, 0, 8'd10, 0, 0, 3'd0, 8'd1, 16'd7));
    vecs.push_back(mk(0, 1, 8'd0,  0,  1, 0, 8'd10, 0, 1, 3'd1, 8'd1, 16'd7));
    vecs.push_back(mk(0, 1, 8'd4,  0,  1, 0, 8'd10, 1, 1, 3'd1, 8'd2, 16'd0));
    vecs.push_back(mk(0, 0, 8'd0,  0,  1, 1, 8'd4,  0, 1, 3'd0, 8'd2, 16'd0));
    vecs.push_back(mk(0, 0, 8'd0,  0,  1, 1, 8'd4,  0, 1, 3'd0, 8'd2, 16'd0));
    vecs.push_back(mk(0, 0, 8'd0,  1,  1, 0, 8'd4,  1, 1, 3'd0, 8'd3, 16'd1));
    vecs.push_back(mk(0, 0, 8'd0,  0,  1, 0, 8'd4,  0, 0, 3'd0, 8'd3, 16'd1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].tc, vecs[i].d);
      step();
      check($sformatf("vec%0d cmd_ready", i), cmd_ready, vecs[i].e_ready);
      check($sformatf("vec%0d disp_start", i), disp_start, vecs[i].e_start);
      check($sformatf("vec%0d disp_thread_count", i), disp_thread_count, vecs[i].e_dtc);
      check($sformatf("vec%0d launch_done", i), launch_done, vecs[i].e_ld);
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d queue_count", i), queue_count, vecs[i].e_cnt);
      check($sformatf("vec%0d launches_completed", i), launches_completed, vecs[i].e_comp);
      check($sformatf("vec%0d last_cycles", i), last_cycles, vecs[i].e_last);
    end

    // ---------------- full queue ----------------
    drive(1'b1, 1'b0, 8'd0, 1'b0); step();
    drive(1'b0, 1'b1, 8'd20, 1'b0); step();
    cmd_valid = 1'b0; step();
    check("full first launch", disp_start, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cmd_valid = 1'b1; cmd_thread_count = 8'(k); step();
    end
    check("full count", queue_count, 3'd4);
    check("full ready low", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_thread_count = 8'd5; #1;
    check("fifth ready low", cmd_ready, 1'b0);
    step();
    check("fifth blocked", queue_count, 3'd4);
    disp_done = 1'b1; step();
    check("full drain count", queue_count, 3'd4);
    disp_done = 1'b0; step();
    check("full idle count", queue_count, 3'd4);
    step();
    check("first pop count", queue_count, 3'd3);
    check("first pop head", disp_thread_count, 8'd1);
    step();
    check("fifth accepted", queue_count, 3'd4);
    cmd_valid = 1'b0;

    // ---------------- ordering ----------------
    drive(1'b1, 1'b0, 8'd0, 1'b0); step();
    drive(1'b0, 1'b1, 8'd3, 1'b0); step();
    cmd_thread_count = 8'd8; step();
    cmd_thread_count = 8'd1; step();
    cmd_valid = 1'b0;
    begin
      logic [7:0] exp_order [3];
      exp_order[0] = 8'd3; exp_order[1] = 8'd8; exp_order[2] = 8'd1;
      for (int j = 0; j < 3; j++) begin
        wait_start($sformatf("order%0d", j), 20);
        check($sformatf("order%0d thread count", j), disp_thread_count, exp_order[j]);
        step(); step();
        check($sformatf("order%0d stable", j), disp_thread_count, exp_order[j]);
        disp_done = 1'b1; step();
        check($sformatf("order%0d launch_done", j), launch_done, 1'b1);
        disp_done = 1'b0; step();
        check($sformatf("order%0d start gap", j), disp_start, 1'b0);
      end
    end
    step();
    check("order completed", launches_completed, 8'd3);
    check("order busy", busy, 1'b0);

    // ---------------- held done ----------------
    drive(1'b0, 1'b1, 8'd6, 1'b0); step();
    cmd_thread_count = 8'd9; step();
    cmd_valid = 1'b0;
    check("held launch 6", disp_thread_count, 8'd6);
    disp_done = 1'b1; step();
    for (int j = 0; j < 5; j++) begin
      step();
      check($sformatf("held%0d start low", j), disp_start, 1'b0);
      check($sformatf("held%0d no pop", j), queue_count, 3'd1);
    end
    disp_done = 1'b0; step();
    check("held release start low", disp_start, 1'b0);
    step();
    check("held next start", disp_start, 1'b1);
    check("held next thread count", disp_thread_count, 8'd9);

    // ---------------- reset during launch ----------------
    drive(1'b0, 1'b1, 8'd2, 1'b0); step();
    cmd_thread_count = 8'd3; step();
    cmd_valid = 1'b0;
    check("midrst queued", queue_count, 3'd2);
    check("midrst completed before", launches_completed, 8'd4);
    reset = 1'b1; step();
    reset = 1'b0;
    check("midrst start", disp_start, 1'b0);
    check("midrst count", queue_count, 3'd0);
    check("midrst completed", launches_completed, 8'd0);
    check("midrst launch_done", launch_done, 1'b0);
    for (int j = 0; j < 4; j++) begin
      disp_done = (j == 1);
      step();
      check($sformatf("midrst%0d no pulse", j), launch_done, 1'b0);
      check($sformatf("midrst%0d idle", j), busy, 1'b0);
    end

    // ---------------- random traffic against model ----------------
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    model_step(1'b1, 1'b0, 8'd0, 1'b0);
    step();
    for (int c = 0; c < 3000; c++) begin
      logic r, v, d;
      logic [7:0] tc;
      r  = ($urandom_range(0, 399) == 0);
      v  = $urandom_range(0, 1) == 1;
      tc = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      d  = ($urandom_range(0, 3) == 0);
      drive(r, v, tc, d);
      model_step(r, v, tc, d);
      step();
      check($sformatf("rnd%0d cmd_ready", c), cmd_ready, (m_q.size() != DEPTH));
      check($sformatf("rnd%0d disp_start", c), disp_start, m_start);
      check($sformatf("rnd%0d disp_thread_count", c), disp_thread_count, m_dtc);
      check($sformatf("rnd%0d launch_done", c), launch_done, m_ld);
      check($sformatf("rnd%0d busy", c), busy, (m_phase != 0) || (m_q.size() != 0));
      check($sformatf("rnd%0d queue_count", c), queue_count, m_q.size());
      check($sformatf("rnd%0d launches_completed", c), launches_completed, m_comp);
      check($sformatf("rnd%0d last_cycles", c), last_cycles, m_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
